// File: rtl/lfsr_rand_gen_if.sv
// Request/response bundle between a consumer and lfsr_rand_gen.
// Latency: n/a (wires only).
// Backpressure: consumer holds the result by withholding ack; generator holds rnd/valid/fallback.
//
// Signals:
//   req        consumer -> gen  request a new value (sampled in IDLE only)
//   limit      consumer -> gen  exclusive upper bound, captured with req; 0 = full range
//   ack        consumer -> gen  result consumed (sampled in HOLD only)
//   seed_load  consumer -> gen  load seed_value into the LFSR this cycle
//   seed_value consumer -> gen  new seed; zero is replaced by the reset seed
//   rnd        gen -> consumer  result, stable while valid
//   valid      gen -> consumer  rnd holds an unacknowledged result
//   fallback   gen -> consumer  rnd came from the retry-exhaustion path (value 0)
//   busy       gen -> consumer  generator is not idle
interface lfsr_rand_gen_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OUT_W = 8
) ();

  logic             req;
  logic [OUT_W-1:0] limit;
  logic             ack;
  logic             seed_load;
  logic [WIDTH-1:0] seed_value;
  logic [OUT_W-1:0] rnd;
  logic             valid;
  logic             fallback;
  logic             busy;

  // Consumer side.
  modport master (
    output req, limit, ack, seed_load, seed_value,
    input  rnd, valid, fallback, busy
  );

  // Generator side.
  modport slave (
    input  req, limit, ack, seed_load, seed_value,
    output rnd, valid, fallback, busy
  );

endinterface

// File: rtl/lfsr_rand_gen.sv
// Galois-LFSR random generator returning a value in [0, limit) per request via rejection sampling.
// Latency: req edge -> valid is 2 cycles on first-try accept, at most MAX_TRIES+1 cycles.
// Backpressure: result is held in HOLD (valid=1, rnd/fallback stable) until ack; req ignored until back in IDLE.
//
// Ports:
//   clock_i   system clock, all state on its rising edge
//   reset_ni  synchronous active-low reset
//   bus       lfsr_rand_gen_if.slave: req/limit/ack/seed_load/seed_value in, rnd/valid/fallback/busy out
module lfsr_rand_gen #(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
  parameter logic [WIDTH-1:0] SEED      = 16'h00FF,
  parameter int unsigned      OUT_W     = 8,
  parameter int unsigned      MAX_TRIES = 16
) (
  input  logic          clock_i,
  input  logic          reset_ni,
  lfsr_rand_gen_if.slave bus
);

  // Counter must be able to hold 0..MAX_TRIES.
  localparam int unsigned TRIES_W = $clog2(MAX_TRIES + 1);
  // Value of tries at which the current rejection is the last one allowed.
  localparam logic [TRIES_W-1:0] LAST_TRY = TRIES_W'(MAX_TRIES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   lfsr_q, lfsr_d;
  logic [OUT_W-1:0]   rnd_q, rnd_d;
  logic               fallback_q, fallback_d;
  logic [OUT_W-1:0]   limit_q, limit_d;
  logic [TRIES_W-1:0] tries_q, tries_d;

  // ------------------------------------------------------------------
  // Draw decision helpers
  // ------------------------------------------------------------------
  logic [OUT_W-1:0] cand;
  logic             accept;
  logic             exhausted;

  // The candidate is the registered LFSR value, so a seed loaded in one
  // cycle is the candidate examined in the next.
  assign cand      = lfsr_q[OUT_W-1:0];
  // A zero limit means the full OUT_W range, so every candidate passes.
  assign accept    = (limit_q == '0) || (cand < limit_q);
  assign exhausted = (tries_q == LAST_TRY);

  // ------------------------------------------------------------------
  // LFSR next value
  // ------------------------------------------------------------------
  always_comb begin
    lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    // Seed load wins over the advance; a zero seed would lock the
    // register at zero forever, so it is replaced by the reset seed.
    if (bus.seed_load) begin
      lfsr_d = (bus.seed_value == '0) ? SEED : bus.seed_value;
    end
  end

  // ------------------------------------------------------------------
  // Process 1: state register (and datapath registers)
  // ------------------------------------------------------------------
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= SEED;
      rnd_q      <= '0;
      fallback_q <= 1'b0;
      limit_q    <= '0;
      tries_q    <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      rnd_q      <= rnd_d;
      fallback_q <= fallback_d;
      limit_q    <= limit_d;
      tries_q    <= tries_d;
    end
  end

  // ------------------------------------------------------------------
  // Process 2: next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          state_d = ST_DRAW;
        end
      end
      ST_DRAW: begin
        // Either a usable candidate or the retry budget is spent.
        if (accept || exhausted) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath next values, driven by the current state
  // ------------------------------------------------------------------
  always_comb begin
    rnd_d      = rnd_q;
    fallback_d = fallback_q;
    limit_d    = limit_q;
    tries_d    = tries_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          limit_d    = bus.limit;
          tries_d    = '0;
          // fallback stays visible after ack until the next request.
          fallback_d = 1'b0;
        end
      end
      ST_DRAW: begin
        if (accept) begin
          rnd_d = cand;
        end else if (exhausted) begin
          rnd_d      = '0;
          fallback_d = 1'b1;
        end else begin
          tries_d = tries_q + 1'b1;
        end
      end
      default: begin
        // HOLD: everything held; rnd and fallback must stay stable.
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Process 3: outputs
  // ------------------------------------------------------------------
  // valid is exactly "in HOLD": set on the DRAW->HOLD edge and dropped on
  // the ack edge, so it is low in the cycle after ack.
  always_comb begin
    bus.rnd      = rnd_q;
    bus.fallback = fallback_q;
    bus.valid    = (state_q == ST_HOLD);
    bus.busy     = (state_q != ST_IDLE);
  end

endmodule

// File: doc/lfsr_rand_gen.md
Name: lfsr_rand_gen

Overview:
Parametrised Galois-LFSR random number generator. It supersedes the fixed 8-bit free-running generator. Adds configurable width and polynomial, runtime reseeding with lock-up protection, and a req/valid/ack handshake. Each request is range-limited by rejection sampling, with a bounded-retry fallback. It serves game/logic blocks that need a fresh value in [0, limit) on demand.

Parameters:
- WIDTH, 16, LFSR state width in bits (>= OUT_W, >= 4).
- TAPS, 16'hB400, Galois feedback mask. Must describe a maximal-length polynomial for WIDTH.
- SEED, 16'h00FF, value loaded at reset and on a zero seed load. Must be nonzero.
- OUT_W, 8, output value width.
- MAX_TRIES, 16, number of rejections before fallback (>= 1).

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  1  request a new value; sampled only in IDLE.
- limit  in  OUT_W  exclusive upper bound, captured with req. 0 means full range.
- ack  in  1  consumer has taken rnd; sampled only in HOLD.
- seed_load  in  1  load seed_value into the LFSR this cycle.
- seed_value  in  WIDTH  new seed.
- rnd  out  OUT_W  result; stable while valid=1.
- valid  out  1  rnd holds a result not yet acknowledged.
- fallback  out  1  qualifies rnd; retry limit was hit.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (reset=0 at an edge):
  - lfsr=SEED, state=IDLE.
  - rnd=0, valid=0, fallback=0, busy=0.
  - limit_q=0, tries=0.
  - Reset overrides everything, including mid-DRAW and HOLD. Any pending result is discarded.
- LFSR:
  - Free-running; advances every clock when out of reset.
  - Next value = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 0).
  - seed_load=1 has priority over advance: lfsr <= (seed_value==0) ? SEED : seed_value. A zero seed therefore never causes lock-up.
  - Candidate = lfsr[OUT_W-1:0], the current registered value.
- FSM states: IDLE, DRAW, HOLD. busy=1 in DRAW and HOLD.
- IDLE:
  - On req=1: limit_q<=limit, tries<=0, fallback<=0, go to DRAW.
  - Otherwise stay.
- DRAW, once per cycle:
  - Accept when limit_q==0 or candidate<limit_q (unsigned). Then rnd<=candidate, valid<=1, go to HOLD.
  - Otherwise, if tries==MAX_TRIES-1: rnd<=0, fallback<=1, valid<=1, go to HOLD.
  - Otherwise tries<=tries+1 and stay in DRAW.
  - req is ignored in DRAW.
  - A seed_load during DRAW takes effect on the next candidate; the FSM is unaffected.
- HOLD:
  - valid=1; rnd and fallback are held stable.
  - On ack=1: valid<=0 and go to IDLE. valid is low in the cycle after ack.
  - req is ignored in HOLD.
  - A new req is accepted only in IDLE, at the earliest one cycle after ack.
  - ack outside HOLD has no effect.
- Latency:
  - req sampled at edge N gives DRAW in cycle N+1.
  - First-try accept gives valid=1 from cycle N+2 (minimum 2 cycles).
  - Maximum latency is MAX_TRIES+1 cycles.
- fallback is cleared only on the next accepted req or on reset.
- Width rules: tries counter is $clog2(MAX_TRIES+1) bits. The comparison is OUT_W-bit unsigned.

Test Plan:
All scenarios use WIDTH=8, TAPS=8'hB8, SEED=8'h01, OUT_W=8, MAX_TRIES=4.
- Reset, then free-run with no req.
  - lfsr sequence is 01, B8, 5C, 2E, 17, B3.
  - Returns to 01 after exactly 255 cycles; never 00.
  - valid=0, busy=0 throughout.
- req=1 with limit=0 in cycle 0 after reset release.
  - DRAW in cycle 1 with candidate B8.
  - Cycle 2: valid=1, rnd=B8, fallback=0.
  - Holding ack=0 for 10 cycles keeps rnd=B8 and valid=1.
  - ack=1 makes valid=0 in the next cycle.
- Same timing with limit=8'h60.
  - B8 is rejected.
  - 5C is accepted: valid=1 in cycle 3, rnd=5C.
- limit=1 (only 0 is acceptable; the LFSR never yields 0).
  - 4 rejections, then valid=1, rnd=0, fallback=1, 5 cycles after the req edge.
- seed_load=1 with seed_value=0.
  - Next cycle lfsr=01, not 00.
- seed_load with seed_value=5C during DRAW.
  - The next candidate is 5C.
- Control edge cases:
  - reset=0 asserted while in HOLD: next cycle valid=0, busy=0, lfsr=01.
  - req pulsed during DRAW or HOLD is ignored: exactly one result per accepted req.
